// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the display driver and the scan decoder.
//   NUM_DIGITS   number of multiplexed positions
//   SEG_0..SEG_9 glyphs, active-high, bit order gfedcba (bit 0 = segment a)
//   SEG_BLANK    all segments off
//   seg_to_bcd   glyph -> {legal, blank, bcd}
package seg_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef struct packed {
      logic       legal;   // glyph is one of 0-9
      logic       blank;   // all segments off
      logic [3:0] bcd;     // decoded value, 0 unless legal
   } seg_dec_t;

   function automatic seg_dec_t seg_to_bcd(input logic [6:0] seg);
      seg_dec_t r;
      r = '{legal: 1'b1, blank: 1'b0, bcd: 4'd0};
      case (seg)
         SEG_0:     r.bcd = 4'd0;
         SEG_1:     r.bcd = 4'd1;
         SEG_2:     r.bcd = 4'd2;
         SEG_3:     r.bcd = 4'd3;
         SEG_4:     r.bcd = 4'd4;
         SEG_5:     r.bcd = 4'd5;
         SEG_6:     r.bcd = 4'd6;
         SEG_7:     r.bcd = 4'd7;
         SEG_8:     r.bcd = 4'd8;
         SEG_9:     r.bcd = 4'd9;
         SEG_BLANK: begin
            r.legal = 1'b0;
            r.blank = 1'b1;
         end
         default:   r.legal = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one normalised (active-high) {an, seg} sample.
//   seg    in  7  segment lines, bit 0 = a
//   an     in  4  anode selects, bit i = position i
//   legal  out 1  seg is a 0-9 glyph
//   blank  out 1  seg is all off
//   bcd    out 4  decoded digit (valid when legal)
//   idx    out 2  index of the highest active anode
//   onehot out 1  exactly one anode active
//   none   out 1  no anode active
module seg7_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   input  logic [3:0] an,
   output logic       legal,
   output logic       blank,
   output logic [3:0] bcd,
   output logic [1:0] idx,
   output logic       onehot,
   output logic       none
);

   seg_dec_t dec;

   always_comb begin
      dec    = seg_to_bcd(seg);
      legal  = dec.legal;
      blank  = dec.blank;
      bcd    = dec.bcd;
      none   = (an == 4'd0);
      // Clearing the lowest set bit leaves zero only for a single set bit.
      onehot = !none && ((an & (an - 4'd1)) == 4'd0);
      // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
      idx    = 2'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an[i]) idx = 2'(i);
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a 4-digit multiplexed seven-segment display: samples
// seg/an/dp, waits for each anode dwell to settle and decodes it back to BCD.
//   clk_100mhz     in  1  system clock
//   rst            in  1  synchronous active-high reset
//   seg            in  7  segment lines, seg[0]=a .. seg[6]=g
//   an             in  4  anode selects, an[3]=leftmost
//   dp             in  1  decimal point line
//   digit3..digit0 out 4  captured BCD per position
//   digit_valid    out 4  last capture at position i was a 0-9 glyph
//   blank          out 4  last capture at position i was all off
//   dp_mask        out 4  dp at last capture per position (1=lit)
//   frame_done     out 1  pulse: all four positions captured
//   frame_changed  out 1  pulse with frame_done: digits differ from prior frame
//   err            out 1  pulse: illegal glyph or several anodes active
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       clk_100mhz,
   input  logic       rst,
   input  logic [6:0] seg,
   input  logic [3:0] an,
   input  logic       dp,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic [3:0] digit_valid,
   output logic [3:0] blank,
   output logic [3:0] dp_mask,
   output logic       frame_done,
   output logic       frame_changed,
   output logic       err
);

   localparam int              SAMPLE_W   = 12;
   localparam int              CNT_W      = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SETTLE_CYCLES - 1);
   // Raw level of an undriven display: every line at its inactive level.
   localparam logic [SAMPLE_W-1:0] IDLE_RAW = {SAMPLE_W{ACTIVE_LOW}};

   // Sample layout: {an[3:0], seg[6:0], dp}
   logic [SAMPLE_W-1:0] sync1_q, sync2_q, prev_q, sample;
   logic [CNT_W-1:0]    stable_cnt_q;
   logic                armed_q;

   logic [NUM_DIGITS-1:0][3:0] digits_q, digits_nxt, snapshot_q;
   logic [NUM_DIGITS-1:0]      seen_q, seen_nxt;

   logic       d_legal, d_blank, d_onehot, d_none;
   logic [3:0] d_bcd;
   logic [1:0] d_idx;
   logic       settle, capture;

   assign sample = sync2_q ^ IDLE_RAW;   // normalise to active-high

   // Decode the settled sample, not the live one.
   seg7_pattern_decode u_decode (
      .seg    (prev_q[7:1]),
      .an     (prev_q[11:8]),
      .legal  (d_legal),
      .blank  (d_blank),
      .bcd    (d_bcd),
      .idx    (d_idx),
      .onehot (d_onehot),
      .none   (d_none)
   );

   assign settle  = armed_q && (stable_cnt_q == CNT_MAX);
   assign capture = settle && d_onehot;

   always_comb begin
      digits_nxt = digits_q;
      seen_nxt   = seen_q;
      if (capture) begin
         seen_nxt[d_idx] = 1'b1;
         if (d_legal) digits_nxt[d_idx] = d_bcd;
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         sync1_q       <= IDLE_RAW;
         sync2_q       <= IDLE_RAW;
         prev_q        <= '0;
         stable_cnt_q  <= '0;
         armed_q       <= 1'b1;
         digits_q      <= '0;
         snapshot_q    <= '0;
         seen_q        <= '0;
         digit_valid   <= '0;
         blank         <= '0;
         dp_mask       <= '0;
         frame_done    <= 1'b0;
         frame_changed <= 1'b0;
         err           <= 1'b0;
      end else begin
         sync1_q <= {an, seg, dp};
         sync2_q <= sync1_q;
         prev_q  <= sample;

         // A changed sample re-arms, so a new dwell always gets evaluated
         // even if the previous one settled on this very cycle.
         if (sample != prev_q) begin
            stable_cnt_q <= '0;
            armed_q      <= 1'b1;
         end else begin
            if (stable_cnt_q != CNT_MAX) stable_cnt_q <= stable_cnt_q + CNT_W'(1);
            if (settle) armed_q <= 1'b0;
         end

         frame_done    <= 1'b0;
         frame_changed <= 1'b0;
         err           <= 1'b0;
         digits_q      <= digits_nxt;

         if (capture) begin
            dp_mask[d_idx] <= prev_q[0];
            if (d_legal) begin
               digit_valid[d_idx] <= 1'b1;
               blank[d_idx]       <= 1'b0;
            end else if (d_blank) begin
               digit_valid[d_idx] <= 1'b0;
               blank[d_idx]       <= 1'b1;
            end else begin
               digit_valid[d_idx] <= 1'b0;
               blank[d_idx]       <= 1'b0;
               err                <= 1'b1;
            end

            if (&seen_nxt) begin
               seen_q        <= '0;
               frame_done    <= 1'b1;
               frame_changed <= (digits_nxt != snapshot_q);
               snapshot_q    <= digits_nxt;
            end else begin
               seen_q <= seen_nxt;
            end
         end else if (settle && !d_none) begin
            err <= 1'b1;   // several anodes active at once
         end
      end
   end

   assign digit3 = digits_q[3];
   assign digit2 = digits_q[2];
   assign digit1 = digits_q[1];
   assign digit0 = digits_q[0];

endmodule
